// File: rtl/series_pkg.sv
// rtl/series_pkg.sv - Q-format constants, stage record and saturating arithmetic for the series evaluator
package series_pkg;

  localparam int Q_W      = 32;
  localparam int Q_BANK_W = 1;

  localparam logic signed [Q_W-1:0] ONE_Q   = {1'b0, {(Q_W-1){1'b1}}};
  localparam logic signed [Q_W-1:0] POS_MAX = {1'b0, {(Q_W-1){1'b1}}};
  localparam logic signed [Q_W-1:0] NEG_MIN = {1'b1, {(Q_W-1){1'b0}}};

  typedef struct packed {
    logic                    valid;
    logic signed [Q_W-1:0]   x;
    logic signed [Q_W-1:0]   num;
    logic signed [Q_W-1:0]   sum;
    logic [Q_BANK_W-1:0]     bank;
    logic                    sat;
    logic                    ovf;
  } stage_t;

  typedef struct packed {
    logic signed [Q_W-1:0] val;
    logic                  ovf;
  } q_res_t;

  // Only -1.0 * -1.0 leaves the representable range after the Q rescale.
  function automatic q_res_t q_mul(input logic signed [Q_W-1:0] a,
                                   input logic signed [Q_W-1:0] b,
                                   input logic sat);
    logic signed [2*Q_W-1:0] p;
    q_res_t r;
    p     = (2*Q_W)'(a) * (2*Q_W)'(b);
    r.val = Q_W'(p >>> (Q_W-1));
    r.ovf = (a == NEG_MIN) && (b == NEG_MIN);
    if (r.ovf && sat) r.val = POS_MAX;
    return r;
  endfunction

  function automatic q_res_t q_add(input logic signed [Q_W-1:0] a,
                                   input logic signed [Q_W-1:0] b,
                                   input logic sat);
    logic signed [Q_W-1:0] s;
    q_res_t r;
    s     = a + b;
    r.ovf = (a[Q_W-1] == b[Q_W-1]) && (s[Q_W-1] != a[Q_W-1]);
    r.val = s;
    if (r.ovf && sat) r.val = a[Q_W-1] ? NEG_MIN : POS_MAX;
    return r;
  endfunction

endpackage

// File: rtl/series_pipe_eval_stage.sv
// rtl/series_pipe_eval_stage.sv - one series term: accumulate num*c, advance num by x, register the result
module series_stage
  import series_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hold,
  input  logic [Q_W-1:0] coef,
  input  stage_t         in_st,
  output stage_t         out_st
);

  stage_t st_d, st_q;
  q_res_t term, acc, nxt;

  always_comb begin
    term = q_mul(in_st.num, coef, in_st.sat);
    acc  = q_add(in_st.sum, term.val, in_st.sat);
    nxt  = q_mul(in_st.num, in_st.x, in_st.sat);
    st_d     = in_st;
    st_d.num = nxt.val;
    st_d.sum = acc.val;
    st_d.ovf = in_st.ovf | term.ovf | acc.ovf | nxt.ovf;
    if (hold) st_d = st_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  assign out_st = st_q;

endmodule

// File: rtl/series_pipe_eval.sv
// rtl/series_pipe_eval.sv - pipelined banked power-series evaluator with valid/ready stall
module series_pipe_eval
  import series_pkg::*;
#(
  parameter int W       = Q_W,
  parameter int N_TERMS = 4,
  parameter int BANK_W  = Q_BANK_W,
  parameter int IDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_x,
  input  logic [BANK_W-1:0] in_bank,
  input  logic              in_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_sum,
  output logic [W-1:0]      out_x,
  output logic              out_overflow,
  input  logic              cfg_we,
  input  logic [BANK_W-1:0] cfg_bank,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [W-1:0]      cfg_data,
  output logic              ovf_sticky,
  input  logic              ovf_clear
);

  localparam int NUM_BANKS = 2**BANK_W;

  logic [W-1:0] c_q [NUM_BANKS][N_TERMS];
  logic [W-1:0] c_d [NUM_BANKS][N_TERMS];
  logic [W-1:0] coef [N_TERMS];
  stage_t       s0_in;
  stage_t       st_in  [N_TERMS];
  stage_t       st_out [N_TERMS];
  logic         stall;
  logic         sticky_q, sticky_d;

  assign stall    = st_out[N_TERMS-1].valid & ~out_ready;
  assign in_ready = ~stall;

  // Bubbles enter as all-zero records so idle stages and outputs stay quiet.
  always_comb begin
    s0_in = '0;
    if (in_valid && in_ready) begin
      s0_in.valid = 1'b1;
      s0_in.x     = in_x;
      s0_in.num   = ONE_Q;
      s0_in.bank  = in_bank;
      s0_in.sat   = in_sat;
    end
  end

  for (genvar k = 0; k < N_TERMS; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_in[k] = s0_in;
    end else begin : g_rest
      assign st_in[k] = st_out[k-1];
    end
    assign coef[k] = c_q[st_in[k].bank][k];

    series_stage u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (stall),
      .coef   (coef[k]),
      .in_st  (st_in[k]),
      .out_st (st_out[k])
    );
  end

  // Coefficient writes ignore the stall; software keeps in-flight banks untouched.
  always_comb begin
    c_d = c_q;
    if (cfg_we && (int'(cfg_idx) < N_TERMS)) c_d[cfg_bank][cfg_idx] = cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int k = 0; k < N_TERMS; k++)
          c_q[b][k] <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  always_comb begin
    sticky_d = (sticky_q & ~ovf_clear) |
               (st_out[N_TERMS-1].valid & out_ready & st_out[N_TERMS-1].ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign out_valid    = st_out[N_TERMS-1].valid;
  assign out_sum      = st_out[N_TERMS-1].sum;
  assign out_x        = st_out[N_TERMS-1].x;
  assign out_overflow = st_out[N_TERMS-1].ovf;
  assign ovf_sticky   = sticky_q;

endmodule
